// File: rtl/i2c_peripheral_if.sv
// Bundle of I2C pad signals and the user-side byte handshake for i2c_peripheral.
// The slave modport is the peripheral's view; master is the bus/user side.
interface i2c_peripheral_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_out;
  logic       sda_oe;
  logic       busy;
  logic       rw;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_accept;
  logic [7:0] tx_data;
  logic       tx_request;

  modport slave (
    input  scl_in, sda_in, rx_accept, tx_data,
    output sda_out, sda_oe, busy, rw, rx_data, rx_valid, tx_request
  );

  modport master (
    output scl_in, sda_in, rx_accept, tx_data,
    input  sda_out, sda_oe, busy, rw, rx_data, rx_valid, tx_request
  );
endinterface

// File: rtl/i2c_peripheral.sv
// I2C target answering at a fixed 7-bit address. SCL/SDA are oversampled on clk;
// written bytes are handed to user logic, read bytes are pulled from tx_data.
module i2c_peripheral #(
  parameter logic [6:0] ADDRESS = 7'h42
) (
  input logic              clk,
  input logic              reset,
  i2c_peripheral_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;  // remaining read bits, next one at [6]
  logic       rw_q, rw_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_request_q, tx_request_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;

  // Two-flop synchronisers plus previous-value registers for edge detection.
  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[0], bus.scl_in};
    sda_sync_q <= {sda_sync_q[0], bus.sda_in};
    scl_prev_q <= scl_sync_q[1];
    sda_prev_q <= sda_sync_q[1];
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & ~sda_s & sda_prev_q;
  assign stop_det  = scl_s & sda_s & ~sda_prev_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 7'd0;
      tx_shift_q   <= 7'd0;
      rw_q         <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      tx_request_q <= 1'b0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_shift_q   <= tx_shift_d;
      rw_q         <= rw_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_request_q <= tx_request_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic; START/STOP override whatever the byte engine is doing.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_shift_d   = tx_shift_q;
    rw_d         = rw_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    tx_request_d = 1'b0;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;

    if (start_det) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b1;
      state_d   = StAddr;
    end else if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StAddr: begin
          // bit_cnt 8 means address matched and the ACK slot is pending.
          if (scl_rise && bit_cnt_q < 4'd7) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_rise && bit_cnt_q == 4'd7) begin
            if (shift_q == ADDRESS) begin
              rw_d      = sda_s;
              bit_cnt_d = 4'd8;
            end else begin
              state_d = StIgnore;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = StAddrAck;
          end
        end
        StAddrAck: begin
          if (scl_rise && rw_q) tx_request_d = 1'b1;
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              tx_shift_d = bus.tx_data[6:0];
              sda_oe_d   = ~bus.tx_data[7];
              state_d    = StRdByte;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWrByte;
            end
          end
        end
        StWrByte: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = {shift_q, sda_s};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (bus.rx_accept) begin
              sda_oe_d = 1'b1;
              state_d  = StWrAck;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = StWrByte;
          end
        end
        StRdByte: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = StRdAck;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          // bit_cnt 1 marks a controller ACK awaiting the next fall.
          if (scl_rise && bit_cnt_q == 4'd0) begin
            if (!sda_s) begin
              tx_request_d = 1'b1;
              bit_cnt_d    = 4'd1;
            end else begin
              state_d = StIgnore;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            tx_shift_d = bus.tx_data[6:0];
            sda_oe_d   = ~bus.tx_data[7];
            bit_cnt_d  = 4'd0;
            state_d    = StRdByte;
          end
        end
        StIgnore: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.sda_out    = 1'b0;
  assign bus.sda_oe     = sda_oe_q;
  assign bus.busy       = busy_q;
  assign bus.rw         = rw_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.tx_request = tx_request_q;

endmodule

// File: tb/tb_i2c_peripheral.sv
// Bench for i2c_peripheral: a bit-banged controller drives the open-drain bus,
// a directed vector table and random transactions are checked against a
// transaction-level model, plus repeated-START and reset-mid-read sequences.
module tb_i2c_peripheral;
  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic reset;
  logic scl;
  logic ctrl_sda;
  logic sda_line;

  always #5 clk = ~clk;

  i2c_peripheral_if bus ();

  assign sda_line   = ctrl_sda & ~bus.sda_oe;
  assign bus.scl_in = scl;
  assign bus.sda_in = sda_line;

  i2c_peripheral #(.ADDRESS(7'h42)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int passed = 0;

  logic [7:0] rx_log[$];
  int         txreq_cnt = 0;
  int         oe_cnt = 0;
  logic       model_rw = 1'b0;

  // Passive monitor of the user-side pulses and SDA drive.
  always @(negedge clk) begin
    if (bus.rx_valid) rx_log.push_back(bus.rx_data);
    if (bus.tx_request) txreq_cnt++;
    if (bus.sda_oe) oe_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[31-8*i -: 8];
  endfunction

  task automatic clock_bit(input logic tx, output logic rx);
    ctrl_sda = tx;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    rx = sda_line;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic start_cond();
    ctrl_sda = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    ctrl_sda = 1'b0;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic stop_cond();
    ctrl_sda = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    ctrl_sda = 1'b1;
    wait_clk(2);
    check("busy_stop_plus2", bus.busy, 1);
    wait_clk(1);
    check("busy_stop_plus3", bus.busy, 0);
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    acked = ~r;
  endtask

  task automatic recv_byte(input logic ack, input logic [7:0] next_tx, output logic [7:0] b);
    logic r;
    bus.tx_data = next_tx;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      b[i] = r;
    end
    clock_bit(~ack, r);
  endtask

  // One START..STOP transaction; flag is rx_accept (write) or controller ACK (read).
  task automatic run_xfer(input logic [6:0] addr, input logic rwb, input int n,
                          input logic [31:0] data, input logic [3:0] flag,
                          output logic aack, output logic [3:0] acks,
                          output logic [31:0] rdata, output int rxn,
                          output logic [31:0] rx, output int txreq, output logic oe);
    int rx_base, tx_base, oe_base;
    logic a;
    logic [7:0] b;
    rx_base = rx_log.size();
    tx_base = txreq_cnt;
    oe_base = oe_cnt;
    acks = '0;
    rdata = '0;
    rx = '0;
    bus.tx_data = byte_of(data, 0);
    bus.rx_accept = 1'b1;
    start_cond();
    send_byte({addr, rwb}, aack);
    for (int i = 0; i < n; i++) begin
      if (!rwb) begin
        bus.rx_accept = flag[3-i];
        send_byte(byte_of(data, i), a);
        acks[3-i] = a;
      end else begin
        recv_byte(flag[3-i], (i + 1 < n) ? byte_of(data, i + 1) : 8'h00, b);
        rdata[31-8*i -: 8] = b;
      end
    end
    stop_cond();
    rxn = rx_log.size() - rx_base;
    for (int j = 0; j < rxn && j < 4; j++) rx[31-8*j -: 8] = rx_log[rx_base + j];
    txreq = txreq_cnt - tx_base;
    oe = (oe_cnt != oe_base);
  endtask

  // Transaction-level expectations: who acknowledges, what is delivered, what reads back.
  task automatic model_xfer(input logic [6:0] addr, input logic rwb, input int n,
                            input logic [31:0] data, input logic [3:0] flag,
                            output logic aack, output logic [3:0] acks,
                            output logic [31:0] rdata, output int rxn,
                            output logic [31:0] rx, output int txreq, output logic oe);
    logic active;
    active = (addr == 7'h42);
    aack = active;
    oe = active;
    if (active) model_rw = rwb;
    acks = '0;
    rdata = '0;
    rx = '0;
    rxn = 0;
    txreq = (active && rwb) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      if (!rwb) begin
        if (active) begin
          rx[31-8*rxn -: 8] = byte_of(data, i);
          rxn++;
          acks[3-i] = flag[3-i];
          active = flag[3-i];
        end
      end else begin
        rdata[31-8*i -: 8] = active ? byte_of(data, i) : 8'hFF;
        if (active && flag[3-i]) txreq++;
        else active = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic        rwb;
    int          n;
    logic [31:0] data;
    logic [3:0]  flag;
    logic        exp_aack;
    logic [3:0]  exp_acks;
    logic [31:0] exp_rdata;
    int          exp_rxn;
    logic [31:0] exp_rx;
    int          exp_txreq;
    logic        exp_oe;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic        aack, eaack, oe, eoe, a;
    logic [3:0]  acks, eacks, flag;
    logic [31:0] rdata, erdata, rx, erx, data;
    int          rxn, erxn, txreq, etxreq, n;
    logic [6:0]  addr;
    logic        rwb;
    logic [7:0]  b;

    vecs[0] = '{7'h42, 1'b0, 2, 32'hA53C_0000, 4'b1100, 1'b1, 4'b1100, 32'h0, 2,
                32'hA53C_0000, 0, 1'b1, 1'b0};
    vecs[1] = '{7'h43, 1'b0, 1, 32'h1100_0000, 4'b1000, 1'b0, 4'b0000, 32'h0, 0,
                32'h0, 0, 1'b0, 1'b0};
    vecs[2] = '{7'h42, 1'b1, 2, 32'h960F_0000, 4'b1000, 1'b1, 4'b0000, 32'h960F_0000, 0,
                32'h0, 2, 1'b1, 1'b1};
    vecs[3] = '{7'h42, 1'b0, 3, 32'h0102_0300, 4'b1010, 1'b1, 4'b1000, 32'h0, 2,
                32'h0102_0000, 0, 1'b1, 1'b0};
    vecs[4] = '{7'h21, 1'b1, 1, 32'h7700_0000, 4'b0000, 1'b0, 4'b0000, 32'hFF00_0000, 0,
                32'h0, 0, 1'b0, 1'b0};

    reset = 1'b1;
    scl = 1'b1;
    ctrl_sda = 1'b1;
    bus.rx_accept = 1'b0;
    bus.tx_data = 8'h00;
    wait_clk(5);
    check("rst_sda_out", bus.sda_out, 0);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rw", bus.rw, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_tx_request", bus.tx_request, 0);
    reset = 1'b0;
    wait_clk(3);

    // Directed vector table.
    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].addr, vecs[i].rwb, vecs[i].n, vecs[i].data, vecs[i].flag,
               aack, acks, rdata, rxn, rx, txreq, oe);
      check($sformatf("vec%0d_addr_ack", i), aack, vecs[i].exp_aack);
      check($sformatf("vec%0d_byte_acks", i), acks, vecs[i].exp_acks);
      check($sformatf("vec%0d_read_data", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_rx_count", i), rxn, vecs[i].exp_rxn);
      check($sformatf("vec%0d_rx_bytes", i), rx, vecs[i].exp_rx);
      check($sformatf("vec%0d_tx_requests", i), txreq, vecs[i].exp_txreq);
      check($sformatf("vec%0d_sda_driven", i), oe, vecs[i].exp_oe);
      check($sformatf("vec%0d_rw", i), bus.rw, vecs[i].exp_rw);
    end
    model_rw = 1'b0;

    // Repeated START: write 0x10, then read back 0x5A without an intervening STOP.
    bus.rx_accept = 1'b1;
    start_cond();
    send_byte(8'h84, a);
    check("rs_addr_w_ack", a, 1);
    send_byte(8'h10, a);
    check("rs_data_ack", a, 1);
    check("rs_rw_write", bus.rw, 0);
    check("rs_rx_data", bus.rx_data, 8'h10);
    bus.tx_data = 8'h5A;
    start_cond();
    send_byte(8'h85, a);
    check("rs_addr_r_ack", a, 1);
    check("rs_rw_read", bus.rw, 1);
    recv_byte(1'b0, 8'h00, b);
    check("rs_read_byte", b, 8'h5A);
    check("rs_busy_held", bus.busy, 1);
    stop_cond();
    check("rs_rx_data_kept", bus.rx_data, 8'h10);

    // Reset while the peripheral drives a 0 data bit.
    bus.tx_data = 8'h3F;
    start_cond();
    send_byte(8'h85, a);
    check("rst_mid_addr_ack", a, 1);
    check("rst_mid_driving", bus.sda_oe, 1);
    reset = 1'b1;
    wait_clk(1);
    check("rst_mid_sda_oe", bus.sda_oe, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_rw", bus.rw, 0);
    check("rst_mid_rx_data", bus.rx_data, 0);
    check("rst_mid_tx_request", bus.tx_request, 0);
    check("rst_mid_rx_valid", bus.rx_valid, 0);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
    bus.rx_accept = 1'b1;
    start_cond();
    send_byte(8'h84, a);
    check("rst_mid_reack", a, 1);
    stop_cond();

    // Random transactions against the model.
    for (int k = 0; k < 12; k++) begin
      addr = ($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom_range(0, 127));
      rwb = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      data = $urandom;
      flag = 4'($urandom);
      if (rwb) flag[4-n] = 1'b0;  // a controller always NACKs its final read byte
      model_xfer(addr, rwb, n, data, flag, eaack, eacks, erdata, erxn, erx, etxreq, eoe);
      run_xfer(addr, rwb, n, data, flag, aack, acks, rdata, rxn, rx, txreq, oe);
      check($sformatf("rnd%0d_addr_ack", k), aack, eaack);
      check($sformatf("rnd%0d_byte_acks", k), acks, eacks);
      check($sformatf("rnd%0d_read_data", k), rdata, erdata);
      check($sformatf("rnd%0d_rx_count", k), rxn, erxn);
      check($sformatf("rnd%0d_rx_bytes", k), rx, erx);
      check($sformatf("rnd%0d_tx_requests", k), txreq, etxreq);
      check($sformatf("rnd%0d_sda_driven", k), oe, eoe);
      check($sformatf("rnd%0d_rw", k), bus.rw, model_rw);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
